// File: rtl/snake_step_ctrl_if.sv
`default_nettype none
// =====================================================================
// snake_step_ctrl_if : step-strobe / body-stack bus of snake_step_ctrl
// Revision 1.0
// =====================================================================
interface snake_step_ctrl_if #(
    parameter int POS_W = 3,
    parameter int DEPTH = 8
);
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic             tick;
    logic             dir;
    logic             grow;
    logic [POS_W-1:0] posEnt;
    logic             push;
    logic             pop;
    logic [LEN_W-1:0] length;
    logic             full;
    logic             busy;
    logic             tick_miss;

    modport master (
        output tick, dir, grow,
        input  posEnt, push, pop, length, full, busy, tick_miss
    );

    modport slave (
        input  tick, dir, grow,
        output posEnt, push, pop, length, full, busy, tick_miss
    );
endinterface
`default_nettype wire

// File: rtl/snake_step_ctrl.sv
`default_nettype none
// =====================================================================
// snake_step_ctrl : sequences one game step into push / pop strobes
// for the snake body stack. Revision 1.0
// =====================================================================
module snake_step_ctrl #(
    parameter int POS_W     = 3,
    parameter int DEPTH     = 8,
    parameter int HEAD_INIT = 0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    snake_step_ctrl_if.slave  bus
);
    localparam int LEN_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PUSH = 3'd1,
        GAP1 = 3'd2,
        POP  = 3'd3,
        GAP2 = 3'd4
    } state_t;

    state_t           state_q;
    logic [POS_W-1:0] head_q;
    logic [POS_W-1:0] head_d;
    logic [LEN_W-1:0] length_q;
    logic             do_pop_q;
    logic             hold_len_q;
    logic             tick_miss_q;
    logic             at_full;

    assign at_full = (length_q == LEN_W'(DEPTH));
    assign head_d  = bus.dir ? head_q + POS_W'(1) : head_q - POS_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_q      <= POS_W'(HEAD_INIT);
            length_q    <= '0;
            do_pop_q    <= 1'b0;
            hold_len_q  <= 1'b0;
            tick_miss_q <= 1'b0;
        end else begin
            if (bus.tick && state_q != IDLE)
                tick_miss_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus.tick) begin
                        head_q     <= head_d;
                        do_pop_q   <= (!bus.grow && length_q != '0) || at_full;
                        // A step taken at full pushes and pops with no net length change.
                        hold_len_q <= at_full;
                        state_q    <= PUSH;
                    end
                end
                PUSH: begin
                    if (!hold_len_q)
                        length_q <= length_q + LEN_W'(1);
                    state_q <= GAP1;
                end
                GAP1:    state_q <= do_pop_q ? POP : IDLE;
                POP: begin
                    if (!hold_len_q)
                        length_q <= length_q - LEN_W'(1);
                    state_q <= GAP2;
                end
                GAP2:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.posEnt    = head_q;
    assign bus.push      = (state_q == PUSH);
    assign bus.pop       = (state_q == POP);
    assign bus.busy      = (state_q != IDLE);
    assign bus.length    = length_q;
    assign bus.full      = at_full;
    assign bus.tick_miss = tick_miss_q;
endmodule
`default_nettype wire

// File: tb/tb_snake_step_ctrl.sv
`default_nettype none
// =====================================================================
// tb_snake_step_ctrl : vector table, hand sequences and random steps
// against a step-level reference model. Revision 1.0
// =====================================================================
module tb_snake_step_ctrl;
    localparam int POS_W     = 3;
    localparam int DEPTH     = 8;
    localparam int HEAD_INIT = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchecks = 0;
    int   nerrors = 0;
    int   cur_len = 0;

    always #5 clk = ~clk;

    snake_step_ctrl_if #(.POS_W(POS_W), .DEPTH(DEPTH)) bus ();

    snake_step_ctrl #(.POS_W(POS_W), .DEPTH(DEPTH), .HEAD_INIT(HEAD_INIT)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic d;
        logic g;
        int   inj;
        int   pos;
        int   len;
        bit   pop;
        bit   miss;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ":push"},   int'(bus.push), 0);
        check({tag, ":pop"},    int'(bus.pop), 0);
        check({tag, ":busy"},   int'(bus.busy), 0);
        check({tag, ":length"}, int'(bus.length), 0);
        check({tag, ":full"},   int'(bus.full), 0);
        check({tag, ":miss"},   int'(bus.tick_miss), 0);
        check({tag, ":posEnt"}, int'(bus.posEnt), HEAD_INIT);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        bus.tick = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_idle_reset(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cur_len = 0;
    endtask

    // One accepted step; inj = cycle (1..busy length) whose ending edge sees an extra tick.
    task automatic run_step(input logic d, input logic g, input int inj, input int e_pos,
                            input int e_len, input bit e_pop, input bit e_miss, input string tag);
        int busylen;
        bit was_full;
        busylen  = e_pop ? 4 : 2;
        was_full = (cur_len == DEPTH);
        bus.tick = 1'b1;
        bus.dir  = d;
        bus.grow = g;
        @(posedge clk); #1;
        bus.tick = 1'b0;
        bus.dir  = ~d;
        bus.grow = ~g;
        for (int j = 1; j <= busylen + 1; j++) begin
            check({tag, ":push"},   int'(bus.push), int'(j == 1));
            check({tag, ":pop"},    int'(bus.pop), int'(e_pop && j == 3));
            check({tag, ":busy"},   int'(bus.busy), int'(j <= busylen));
            check({tag, ":posEnt"}, int'(bus.posEnt), e_pos);
            if (was_full)
                check({tag, ":full_hold"}, int'(bus.full), 1);
            if (j <= busylen) begin
                bus.tick = (j == inj);
                @(posedge clk); #1;
            end
        end
        bus.tick = 1'b0;
        check({tag, ":length"}, int'(bus.length), e_len);
        check({tag, ":full"},   int'(bus.full), int'(e_len == DEPTH));
        check({tag, ":miss"},   int'(bus.tick_miss), int'(e_miss));
        cur_len = e_len;
    endtask

    initial begin
        int  m_head, m_len, m_pos, m_newlen, inj;
        bit  m_pop, m_miss;
        logic d, g;

        bus.tick = 1'b0;
        bus.dir  = 1'b0;
        bus.grow = 1'b0;

        //            d  g  inj pos len pop miss
        tbl[0]  = '{1'b1, 1'b0, 0, 1, 1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2, 2, 1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1, 1, 2, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 0, 0, 3, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 0, 7, 4, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 4, 6, 4, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 0, 7, 5, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 0, 0, 6, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 0, 1, 7, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 0, 2, 8, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 0, 3, 8, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 0, 2, 8, 1'b1, 1'b1};

        #12;
        check_idle_reset("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_step(tbl[i].d, tbl[i].g, tbl[i].inj, tbl[i].pos, tbl[i].len,
                     tbl[i].pop, tbl[i].miss, $sformatf("vec%0d", i));

        // Reset landing in the middle of the POP cycle.
        do_reset("rst_a");
        run_step(1'b1, 1'b0, 0, 1, 1, 1'b0, 1'b0, "pre_pop");
        bus.tick = 1'b1;
        bus.dir  = 1'b1;
        bus.grow = 1'b0;
        @(posedge clk); #1;
        bus.tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midpop:pop_before", int'(bus.pop), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_reset("midpop");
        @(posedge clk); #1;
        check("midpop:pop_held", int'(bus.pop), 0);
        rst_n = 1'b1;
        cur_len = 0;
        run_step(1'b0, 1'b1, 0, 7, 1, 1'b0, 1'b0, "first_after_rst");

        // Random steps against the step-level model.
        do_reset("rst_b");
        m_head = HEAD_INIT;
        m_len  = 0;
        m_miss = 1'b0;
        for (int n = 0; n < 150; n++) begin
            d = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 2) == 0);
            m_pos    = (m_head + (d ? 1 : -1)) & ((1 << POS_W) - 1);
            m_pop    = (!g && m_len >= 1) || (m_len == DEPTH);
            m_newlen = m_len + ((g || m_len == 0) ? 1 : 0);
            if (m_newlen > DEPTH)
                m_newlen = DEPTH;
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, m_pop ? 4 : 2) : 0;
            if (inj != 0)
                m_miss = 1'b1;
            run_step(d, g, inj, m_pos, m_newlen, m_pop, m_miss, $sformatf("rnd%0d", n));
            m_head = m_pos;
            m_len  = m_newlen;
            if ($urandom_range(0, 19) == 0) begin
                do_reset($sformatf("rnd_rst%0d", n));
                m_head = HEAD_INIT;
                m_len  = 0;
                m_miss = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
`default_nettype wire
